mod_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 28 ++
 rtl/bin_to_bcd.sv | 31 +++
 rtl/mod_counter.sv | 106 ++++++++++
 tb/tb_mod_counter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo counter family.
package counter_pkg;

  localparam int BCD_DIGIT_W = 4;

  // Behaviour at the range ends: roll over, or stick at the end value.
  typedef enum logic {
    WRAP     = 1'b0,
    SATURATE = 1'b1
  } count_mode_e;

  // Decimal digits needed to show the largest count (modulus-1).
  // The loop bound covers any 32-bit modulus.
  function automatic int bcd_digits_needed(input int modulus);
    int v;
    int n;
    v = modulus - 1;
    n = 1;
    for (int i = 0; i < 10; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational binary to packed BCD converter (double-dabble / shift-add-3).
// Digit 0 lands in bcd[3:0]; digits above the value's magnitude read 0.
module bin_to_bcd
  import counter_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 3
) (
  input  logic [WIDTH-1:0]              bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int BW = BCD_DIGIT_W * DIGITS;

  logic [BW-1:0] acc;

  // Shift the binary in MSB first, adjusting each digit >= 5 before each shift.
  always_comb begin
    acc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (acc[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5)
          acc[d*BCD_DIGIT_W +: BCD_DIGIT_W] = acc[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
      end
      acc = {acc[BW-2:0], bin[i]};
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with clear, clamped load, wrap or
// saturate at the range ends, a combinational terminal count for cascading,
// a registered wrap pulse and a packed BCD view of the count.
module mod_counter #(
  parameter int WIDTH    = 7,
  parameter int MODULUS  = 100,
  parameter int SATURATE = 0,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  wrap,
  output logic [4*DIGITS-1:0]   bcd
);

  import counter_pkg::*;

  // The local parameter SATURATE shadows the enum literal, so name it fully.
  localparam count_mode_e MODE = (SATURATE != 0) ? counter_pkg::SATURATE : WRAP;
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  // Illegal parameter combinations stop elaboration.
  generate
    if (MODULUS < 2) begin : g_chk_mod_min
      $fatal(1, "mod_counter: MODULUS must be >= 2");
    end
    if (WIDTH < 1 || WIDTH > 31) begin : g_chk_width
      $fatal(1, "mod_counter: WIDTH must be in 1..31");
    end
    if (((MODULUS - 1) >> WIDTH) != 0) begin : g_chk_mod_fit
      $fatal(1, "mod_counter: MODULUS must be <= 2**WIDTH");
    end
    if (DIGITS < 1 || bcd_digits_needed(MODULUS) > DIGITS) begin : g_chk_digits
      $fatal(1, "mod_counter: DIGITS too small for MODULUS");
    end
    if (SATURATE != 0 && SATURATE != 1) begin : g_chk_sat
      $fatal(1, "mod_counter: SATURATE must be 0 or 1");
    end
  endgenerate

  logic             at_top;
  logic             at_bottom;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // >= rather than == so an out-of-range count recovers on the next up step.
  assign at_top    = (count >= TOP);
  assign at_bottom = (count == '0);

  // Combinational so a following stage can use it as its enable this cycle.
  assign tc = en & ((up & at_top) | (~up & at_bottom));

  // Next count and wrap flag: clear > load > en > hold.
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > TOP) ? TOP : load_val;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          count_nxt = count + 1'b1;
        end else if (MODE == WRAP) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end
      end else begin
        if (!at_bottom) begin
          count_nxt = count - 1'b1;
        end else if (MODE == WRAP) begin
          count_nxt = TOP;
          wrap_nxt  = 1'b1;
        end
      end
    end
  end

  // Count register and wrap pulse flop; reset clears both immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  bin_to_bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bcd (
    .bin (count),
    .bcd (bcd)
  );

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: five instances (decimal wrap, decimal
// saturate, modulo-2, and a 10/6 cascade) share one randomised stimulus
// stream and are compared against a plain-arithmetic model every cycle.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
  logic [6:0] lv = '0;

  logic [6:0]  cnt_w, cnt_s;
  logic [0:0]  cnt_2;
  logic [3:0]  cnt_c1;
  logic [2:0]  cnt_c2;
  logic        tc_w, tc_s, tc_2, tc_c1, tc_c2;
  logic        wr_w, wr_s, wr_2, wr_c1, wr_c2;
  logic [11:0] bcd_w, bcd_s;
  logic [3:0]  bcd_2, bcd_c1, bcd_c2;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(7), .MODULUS(100), .SATURATE(0), .DIGITS(3)) u_wrap (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv), .count(cnt_w), .tc(tc_w), .wrap(wr_w), .bcd(bcd_w));

  mod_counter #(.WIDTH(7), .MODULUS(100), .SATURATE(1), .DIGITS(3)) u_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv), .count(cnt_s), .tc(tc_s), .wrap(wr_s), .bcd(bcd_s));

  mod_counter #(.WIDTH(1), .MODULUS(2), .SATURATE(0), .DIGITS(1)) u_m2 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(lv[0:0]), .count(cnt_2), .tc(tc_2), .wrap(wr_2), .bcd(bcd_2));

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .DIGITS(1)) u_c1 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(1'b1), .clear(clear), .load(load),
    .load_val(lv[3:0]), .count(cnt_c1), .tc(tc_c1), .wrap(wr_c1), .bcd(bcd_c1));

  mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0), .DIGITS(1)) u_c2 (
    .clk(clk), .reset_n(reset_n), .en(tc_c1), .up(1'b1), .clear(clear), .load(1'b0),
    .load_val(3'd0), .count(cnt_c2), .tc(tc_c2), .wrap(wr_c2), .bcd(bcd_c2));

  // ---------------- reference model ----------------
  int MODS[5] = '{100, 100, 2, 10, 6};
  bit SATS[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int mc[5];
  bit mw[5];

  typedef struct packed {
    logic [4:0][7:0] c;
    logic [4:0]      w;
    logic [4:0]      t;
    logic [11:0]     bcd;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic bit tcm(input int m, input bit e, input bit u, input int M);
    return e && (u ? (m == M - 1) : (m == 0));
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] b;
    int p;
    b = '0;
    p = 1;
    for (int d = 0; d < 3; d++) begin
      b[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return b;
  endfunction

  // One clock of a counter of range 0..M-1 following the stated rules.
  task automatic mstep(input int m, input bit e, input bit u, input bit c, input bit l,
                       input int v, input int M, input bit sat,
                       output int nm, output bit nw);
    nm = m;
    nw = 1'b0;
    if (c) nm = 0;
    else if (l) nm = (v < M) ? v : M - 1;
    else if (e) begin
      if (u) begin
        if (m + 1 < M) nm = m + 1;
        else if (!sat) begin nm = 0; nw = 1'b1; end
      end else begin
        if (m > 0) nm = m - 1;
        else if (!sat) begin nm = M - 1; nw = 1'b1; end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, queue what the DUTs
  // must show during this cycle, then advance the model past the next edge.
  task automatic step(input bit r, input bit e, input bit u, input bit c,
                      input bit l, input int v);
    exp_t x;
    bit   ie[5], iu[5], il[5];
    int   iv[5];
    int   nm;
    bit   nw;
    @(negedge clk);
    reset_n = r; en = e; up = u; clear = c; load = l; lv = 7'(v);
    if (!r) for (int i = 0; i < 5; i++) begin mc[i] = 0; mw[i] = 1'b0; end
    for (int i = 0; i < 5; i++) begin
      ie[i] = (i == 4) ? tcm(mc[3], e, 1'b1, MODS[3]) : e;
      iu[i] = (i >= 3) ? 1'b1 : u;
      il[i] = (i == 4) ? 1'b0 : l;
      iv[i] = (i == 2) ? v % 2 : (i == 3) ? v % 16 : (i == 4) ? 0 : v;
      x.c[i] = 8'(mc[i]);
      x.w[i] = mw[i];
      x.t[i] = tcm(mc[i], ie[i], iu[i], MODS[i]);
    end
    x.bcd = to_bcd(mc[0]);
    q.push_back(x);
    if (r) for (int i = 0; i < 5; i++) begin
      mstep(mc[i], ie[i], iu[i], c, il[i], iv[i], MODS[i], SATS[i], nm, nw);
      mc[i] = nm;
      mw[i] = nw;
    end
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %0d, want %0d", name, idx, $time, act, exp);
    end
  endtask

  // Monitor: every cycle, compare the DUT outputs with the queued record.
  initial begin
    exp_t x;
    int ac[5];
    bit aw[5], at[5];
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        ac = '{int'(cnt_w), int'(cnt_s), int'(cnt_2), int'(cnt_c1), int'(cnt_c2)};
        aw = '{wr_w, wr_s, wr_2, wr_c1, wr_c2};
        at = '{tc_w, tc_s, tc_2, tc_c1, tc_c2};
        for (int i = 0; i < 5; i++) begin
          chk("count", i, ac[i], int'(x.c[i]));
          chk("wrap",  i, int'(aw[i]), int'(x.w[i]));
          chk("tc",    i, int'(at[i]), int'(x.t[i]));
        end
        chk("bcd", 0, int'(bcd_w), int'(x.bcd));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 5; i++) begin mc[i] = 0; mw[i] = 1'b0; end
    // reset held with en high, then release: first edge counts to 1
    repeat (5) step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    // full up wrap 0..99..0; cascade 10x6 returns to 0/0 after 60 steps
    step(1, 0, 1, 1, 0, 0);
    repeat (101) step(1, 1, 1, 0, 0, 0);
    // down from 0: wrap to 99 vs saturate at 0
    step(1, 0, 1, 1, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    // load beats en, clamp above range, clear beats load
    step(1, 1, 1, 0, 1, 42);
    step(1, 1, 1, 0, 1, 120);
    step(1, 1, 1, 1, 1, 42);
    step(1, 0, 1, 0, 0, 0);
    // async reset between edges with count at 57
    step(1, 0, 1, 0, 1, 57);
    step(1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    // randomised traffic
    repeat (600) begin
      step(($urandom_range(99) != 0), ($urandom_range(3) != 0), 1'($urandom),
           ($urandom_range(99) < 3), ($urandom_range(99) < 5),
           int'($urandom_range(127)));
    end
    step(1, 0, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    #4;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending records, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
